kmap_lut_engine: RTL and testbench

Runtime-programmable N-input Boolean function unit. It stores a 2^N-entry truth table and evaluates input vectors through a valid/ready handshake with one cycle of latency. The table reloads serially while the unit keeps evaluating, and the new table takes effect atomically. It succeeds the fixed 4-input K-map blocks in the combinational-logic problem set; its reset table is the N-input odd-parity function (16'h6996 for N=4).

---
 rtl/kmap_lut_engine.sv | 125 ++++++++++++
 tb/tb_kmap_lut_engine.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmap_lut_engine.sv
// Runtime-programmable N-input Boolean function: a 2^N-entry truth table evaluated
// through a valid/ready handshake, reloaded serially (MSB first) and committed atomically.
module kmap_lut_engine #(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [N-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic         o_out,
    input  logic         i_prog_en,
    input  logic         i_prog_bit,
    output logic         o_busy,
    output logic         o_load_done,
    output logic         o_load_abort
);
    localparam int TT_W  = 2 ** N;
    localparam int CNT_W = N + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TT_W - 1);

    // Entry i holds the odd parity of the index bits.
    function automatic logic [TT_W-1:0] parity_table();
        logic [TT_W-1:0] t;
        logic [N-1:0]    idx;
        t = '0;
        for (int i = 0; i < TT_W; i++) begin
            idx  = N'(i);
            t[i] = ^idx;
        end
        return t;
    endfunction

    localparam logic [TT_W-1:0] PARITY_TT = parity_table();

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t            r_state, w_state_nxt;
    logic [TT_W-1:0]   r_tt, w_tt_nxt;
    logic [TT_W-2:0]   r_sh, w_sh_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_load_done, w_done_nxt;
    logic              r_load_abort, w_abort_nxt;
    logic              r_out_p1;
    logic              r_vld_p1;
    logic              w_accept;

    // Load FSM: state and shadow register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_tt         <= PARITY_TT;
            r_sh         <= '0;
            r_cnt        <= '0;
            r_load_done  <= 1'b0;
            r_load_abort <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tt         <= w_tt_nxt;
            r_sh         <= w_sh_nxt;
            r_cnt        <= w_cnt_nxt;
            r_load_done  <= w_done_nxt;
            r_load_abort <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tt_nxt    = r_tt;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_prog_en) begin
                    w_sh_nxt    = {r_sh[TT_W-3:0], i_prog_bit};
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!i_prog_en) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_abort_nxt = 1'b1;
                end else if (r_cnt == LAST_CNT) begin
                    // Shadow plus the final bit replaces the whole table in one edge.
                    w_tt_nxt    = {r_sh, i_prog_bit};
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_sh_nxt  = {r_sh[TT_W-3:0], i_prog_bit};
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Evaluation stage p1: one-deep output register with skid-free handshake
    assign o_in_ready = !r_vld_p1 || i_out_ready;
    assign w_accept   = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_p1 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else if (w_accept) begin
            r_out_p1 <= r_tt[i_in_data];
            r_vld_p1 <= 1'b1;
        end else if (i_out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign o_out        = r_out_p1;
    assign o_out_valid  = r_vld_p1;
    assign o_busy       = (r_state == S_LOAD);
    assign o_load_done  = r_load_done;
    assign o_load_abort = r_load_abort;
endmodule

// File: tb/tb_kmap_lut_engine.sv
// Directed bench for kmap_lut_engine: N=4 instance for all features, N=3 for its reset table.
module tb_kmap_lut_engine;
    logic       clk;
    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready, out_bit;
    logic [3:0] in_data;
    logic       prog_en, prog_bit, busy, load_done, load_abort;
    logic       in_valid3, in_ready3, out_valid3, out_ready3, out3;
    logic [2:0] in_data3;
    logic       busy3, done3, abort3;
    int         total;
    int         bad;

    kmap_lut_engine #(.N(4)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out(out_bit),
        .i_prog_en(prog_en), .i_prog_bit(prog_bit),
        .o_busy(busy), .o_load_done(load_done), .o_load_abort(load_abort)
    );

    kmap_lut_engine #(.N(3)) dut3 (
        .i_clk(clk), .i_reset(reset),
        .i_in_valid(in_valid3), .o_in_ready(in_ready3), .i_in_data(in_data3),
        .o_out_valid(out_valid3), .i_out_ready(out_ready3), .o_out(out3),
        .i_prog_en(1'b0), .i_prog_bit(1'b0),
        .o_busy(busy3), .o_load_done(done3), .o_load_abort(abort3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 1'b0 || out_bit !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got vld=%b out=%b busy=%b rdy=%b exp vld=0 out=0 busy=0 rdy=1",
                     out_valid, out_bit, busy, in_ready);
        end
        total++;
        if (load_done !== 1'b0 || load_abort !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses got done=%b abort=%b exp 0 0", load_done, load_abort);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] exp_tt;
        exp_tt    = 16'h6996;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            step();
            total++;
            if (out_valid !== 1'b1 || out_bit !== exp_tt[i]) begin
                bad++;
                $display("FAIL sweep[%0d] got vld=%b out=%b exp vld=1 out=%b", i, out_valid, out_bit, exp_tt[i]);
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL sweep_drain got vld=%b exp 0", out_valid);
        end
    endtask

    task automatic test_full_load();
        logic [15:0] v;
        v = 16'h8000;
        for (int k = 0; k < 16; k++) begin
            prog_en  = 1'b1;
            prog_bit = v[15-k];
            step();
            total++;
            if (k < 15) begin
                if (busy !== 1'b1 || load_done !== 1'b0) begin
                    bad++;
                    $display("FAIL load_busy[%0d] got busy=%b done=%b exp busy=1 done=0", k, busy, load_done);
                end
            end else if (busy !== 1'b0 || load_done !== 1'b1) begin
                bad++;
                $display("FAIL load_commit got busy=%b done=%b exp busy=0 done=1", busy, load_done);
            end
        end
        prog_en = 1'b0;
        step();
        total++;
        if (load_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL load_done_once got done=%b busy=%b exp 0 0", load_done, busy);
        end
        in_valid = 1'b1; in_data = 4'hf; step();
        total++;
        if (out_bit !== 1'b1) begin bad++; $display("FAIL load_eval_f got %b exp 1", out_bit); end
        in_data = 4'he; step();
        total++;
        if (out_bit !== 1'b0) begin bad++; $display("FAIL load_eval_e got %b exp 0", out_bit); end
        in_data = 4'h0; step();
        total++;
        if (out_bit !== 1'b0) begin bad++; $display("FAIL load_eval_0 got %b exp 0", out_bit); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_abort();
        logic [15:0] v;
        v = 16'h0001;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            prog_en  = 1'b1;
            prog_bit = v[15-k];
            step();
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy got %b exp 1", busy); end
        prog_en = 1'b0;
        step();
        total++;
        if (load_abort !== 1'b1 || busy !== 1'b0 || load_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_pulse got abort=%b busy=%b done=%b exp 1 0 0", load_abort, busy, load_done);
        end
        step();
        total++;
        if (load_abort !== 1'b0) begin bad++; $display("FAIL abort_once got %b exp 0", load_abort); end
        in_valid = 1'b1; in_data = 4'h1; step();
        total++;
        if (out_bit !== 1'b1) begin bad++; $display("FAIL abort_eval_1 got %b exp 1", out_bit); end
        in_data = 4'h0; step();
        total++;
        if (out_bit !== 1'b0) begin bad++; $display("FAIL abort_eval_0 got %b exp 0", out_bit); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_collision();
        for (int k = 0; k < 16; k++) begin
            prog_en  = 1'b1;
            prog_bit = 1'b1;
            in_valid = (k == 15);
            in_data  = 4'h0;
            step();
        end
        prog_en = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_bit !== 1'b0 || load_done !== 1'b1) begin
            bad++;
            $display("FAIL collide_old got vld=%b out=%b done=%b exp 1 0 1", out_valid, out_bit, load_done);
        end
        in_data = 4'h0; step();
        total++;
        if (out_bit !== 1'b1) begin bad++; $display("FAIL collide_new_0 got %b exp 1", out_bit); end
        in_data = 4'h5; step();
        total++;
        if (out_bit !== 1'b1) begin bad++; $display("FAIL collide_new_5 got %b exp 1", out_bit); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        a = 16'h00ff;
        b = 16'h0f0f;
        for (int k = 0; k < 32; k++) begin
            prog_en  = 1'b1;
            prog_bit = (k < 16) ? a[15-k] : b[31-k];
            step();
            if (k == 15) begin
                total++;
                if (load_done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got %b exp 1", load_done); end
            end else if (k == 16) begin
                total++;
                if (busy !== 1'b1 || load_done !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_restart got busy=%b done=%b exp 1 0", busy, load_done);
                end
            end
        end
        prog_en = 1'b0;
        total++;
        if (load_done !== 1'b1) begin bad++; $display("FAIL b2b_second_done got %b exp 1", load_done); end
        in_valid = 1'b1; in_data = 4'h3; step();
        total++;
        if (out_bit !== 1'b1) begin bad++; $display("FAIL b2b_eval_3 got %b exp 1", out_bit); end
        in_data = 4'h4; step();
        total++;
        if (out_bit !== 1'b0) begin bad++; $display("FAIL b2b_eval_4 got %b exp 0", out_bit); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h1;
        step();
        in_data = 4'h3;
        total++;
        if (out_valid !== 1'b1 || out_bit !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_first got vld=%b out=%b rdy=%b exp 1 1 0", out_valid, out_bit, in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_bit !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] got vld=%b out=%b rdy=%b exp 1 1 0", c, out_valid, out_bit, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_rdy got %b exp 1", in_ready); end
        step();
        total++;
        if (out_valid !== 1'b1 || out_bit !== 1'b0) begin
            bad++;
            $display("FAIL bp_release_eval got vld=%b out=%b exp 1 0", out_valid, out_bit);
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_midload();
        for (int k = 0; k < 9; k++) begin
            prog_en  = 1'b1;
            prog_bit = 1'b1;
            step();
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got %b exp 1", busy); end
        prog_en = 1'b0;
        reset   = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || load_done !== 1'b0 || load_abort !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got busy=%b done=%b abort=%b exp 0 0 0", busy, load_done, load_abort);
        end
        step();
        total++;
        if (load_done !== 1'b0 || load_abort !== 1'b0) begin
            bad++;
            $display("FAIL mid_nopulse got done=%b abort=%b exp 0 0", load_done, load_abort);
        end
        in_valid = 1'b1; in_data = 4'h1; step();
        total++;
        if (out_bit !== 1'b1) begin bad++; $display("FAIL mid_eval_1 got %b exp 1", out_bit); end
        in_data = 4'h3; step();
        total++;
        if (out_bit !== 1'b0) begin bad++; $display("FAIL mid_eval_3 got %b exp 0", out_bit); end
        in_data = 4'h7; step();
        total++;
        if (out_bit !== 1'b1) begin bad++; $display("FAIL mid_eval_7 got %b exp 1", out_bit); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_n3();
        out_ready3 = 1'b1;
        in_valid3  = 1'b1;
        in_data3   = 3'b111; step();
        total++;
        if (out_valid3 !== 1'b1 || out3 !== 1'b1) begin
            bad++;
            $display("FAIL n3_eval_7 got vld=%b out=%b exp 1 1", out_valid3, out3);
        end
        in_data3 = 3'b011; step();
        total++;
        if (out3 !== 1'b0) begin bad++; $display("FAIL n3_eval_3 got %b exp 0", out3); end
        in_data3 = 3'b100; step();
        total++;
        if (out3 !== 1'b1) begin bad++; $display("FAIL n3_eval_4 got %b exp 1", out3); end
        in_valid3 = 1'b0;
        step();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        prog_en    = 1'b0;
        prog_bit   = 1'b0;
        in_valid3  = 1'b0;
        in_data3   = '0;
        out_ready3 = 1'b1;
        test_reset();
        test_sweep();
        test_full_load();
        test_abort();
        test_collision();
        test_back_to_back();
        test_backpressure();
        test_reset_midload();
        test_n3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
